// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length high windows separated by
// a mandatory low gap, queueing events that arrive mid-blink in a saturating counter.
module pulse_stretcher #(
    parameter  int HOLD_CYCLES = 12500000,
    parameter  int GAP_CYCLES  = 12500000,
    parameter  int MAX_PEND    = 7,
    localparam int PW          = $clog2(MAX_PEND + 1)
) (
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          Pin,
    output logic          Lout,
    output logic          Busy,
    output logic [PW-1:0] Pending,
    output logic          Overflow
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PEND_FULL = PW'(MAX_PEND);
    localparam logic [PW-1:0] PEND_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state_r,  state_nxt_s;
    logic [CW-1:0] cnt_r,    cnt_nxt_s;
    logic [PW-1:0] pend_r,   pend_nxt_s;
    logic          lout_r,   lout_nxt_s;
    logic          busy_r,   busy_nxt_s;
    logic          ovf_r,    ovf_nxt_s;
    logic          full_s;
    logic [PW-1:0] pend_inc_s;

    // Saturating increment used whenever a mid-blink event is queued
    always_comb begin
        full_s     = (pend_r == PEND_FULL);
        pend_inc_s = full_s ? pend_r : (pend_r + PEND_ONE);
    end

    // Next-state logic for the blink sequencer and event queue
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pend_nxt_s  = pend_r;
        lout_nxt_s  = lout_r;
        busy_nxt_s  = busy_r;
        ovf_nxt_s   = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (Pin) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = HOLD_LOAD;
                    lout_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b1;
                end else begin
                    lout_nxt_s  = 1'b0;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = GAP_LOAD;
                    lout_nxt_s  = 1'b0;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
                if (Pin) begin
                    pend_nxt_s = pend_inc_s;
                    ovf_nxt_s  = ovf_r | full_s;
                end else begin
                    pend_nxt_s = pend_r;
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    if (pend_r != PEND_ZERO) begin
                        // A queued event starts; a coincident Pin takes its slot, so no drop
                        state_nxt_s = ST_HOLD;
                        cnt_nxt_s   = HOLD_LOAD;
                        lout_nxt_s  = 1'b1;
                        pend_nxt_s  = Pin ? pend_r : (pend_r - PEND_ONE);
                    end else if (Pin) begin
                        state_nxt_s = ST_HOLD;
                        cnt_nxt_s   = HOLD_LOAD;
                        lout_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        busy_nxt_s  = 1'b0;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (Pin) begin
                        pend_nxt_s = pend_inc_s;
                        ovf_nxt_s  = ovf_r | full_s;
                    end else begin
                        pend_nxt_s = pend_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                pend_nxt_s  = PEND_ZERO;
                lout_nxt_s  = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            pend_r  <= PEND_ZERO;
            lout_r  <= 1'b0;
            busy_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pend_r  <= pend_nxt_s;
            lout_r  <= lout_nxt_s;
            busy_r  <= busy_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign Lout     = lout_r;
    assign Busy     = busy_r;
    assign Pending  = pend_r;
    assign Overflow = ovf_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: an event-timeline model pushes expected
// outputs per cycle; an independent monitor pops and compares them.
module tb_pulse_stretcher;

    localparam int HOLD = 3;
    localparam int GAP  = 2;
    localparam int MAXP = 2;
    localparam int PW   = $clog2(MAXP + 1);

    logic          Clk;
    logic          ResetN;
    logic          Pin;
    logic          Lout;
    logic          Busy;
    logic [PW-1:0] Pending;
    logic          Overflow;

    pulse_stretcher #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .MAX_PEND   (MAXP)
    ) dut (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .Pin     (Pin),
        .Lout    (Lout),
        .Busy    (Busy),
        .Pending (Pending),
        .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic          lout;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
        string         tag;
    } exp_t;

    exp_t  exp_q[$];
    event  mon_ev;
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    // Reference model: position within the current event's HOLD+GAP period
    bit m_active;
    int m_age;
    int m_pend;
    bit m_ovf;

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_pend   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step(input bit p);
        if (!m_active) begin
            if (p) begin
                m_active = 1'b1;
                m_age    = 0;
            end
        end else if (m_age == HOLD + GAP - 1) begin
            if (m_pend > 0) begin
                m_age = 0;
                if (!p) m_pend = m_pend - 1;
            end else if (p) begin
                m_age = 0;
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_age = m_age + 1;
            if (p) begin
                if (m_pend == MAXP) m_ovf = 1'b1;
                else m_pend = m_pend + 1;
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.lout = m_active && (m_age < HOLD);
        e.busy = m_active;
        e.pend = PW'(m_pend);
        e.ovf  = m_ovf;
        e.tag  = phase;
        exp_q.push_back(e);
        -> mon_ev;
    endtask

    task automatic step(input bit p);
        @(negedge Clk);
        Pin = p;
        @(posedge Clk);
        if (ResetN) model_step(p);
        push_expect();
    endtask

    task automatic async_reset(input int cycles);
        @(negedge Clk);
        #2;
        Pin    = 1'b0;
        ResetN = 1'b0;
        model_reset();
        push_expect();
        for (int i = 0; i < cycles; i++) step(1'b0);
        @(negedge Clk);
        ResetN = 1'b1;
    endtask

    task automatic run_pattern(input string name, input int n, input logic [63:0] pat);
        phase = name;
        for (int i = 1; i <= n; i++) step(pat[i]);
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation
    initial begin
        forever begin
            @(mon_ev);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (Lout !== e.lout || Busy !== e.busy || Pending !== e.pend || Overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL %s @%0t: got Lout=%b Busy=%b Pending=%0d Overflow=%b, expected Lout=%b Busy=%b Pending=%0d Overflow=%b",
                             e.tag, $time, Lout, Busy, Pending, Overflow, e.lout, e.busy, e.pend, e.ovf);
                end
            end
        end
    end

    initial begin
        int dens;
        ResetN = 1'b0;
        Pin    = 1'b0;
        model_reset();
        #3;
        push_expect();
        step(1'b0);
        @(negedge Clk);
        ResetN = 1'b1;

        run_pattern("single",      25, 64'h0000_0000_0000_0020);
        run_pattern("queue",       25, 64'h0000_0000_0000_00E0);
        run_pattern("overflow",    25, 64'h0000_0000_0000_01E0);
        run_pattern("gap_end",     20, 64'h0000_0000_0000_0420);
        run_pattern("gap_end_q",   25, 64'h0000_0000_0000_0460);
        run_pattern("pre_reset",   11, 64'h0000_0000_0000_07E0);
        phase = "async_reset";
        async_reset(2);
        run_pattern("post_reset",  15, 64'h0000_0000_0000_0004);

        phase = "random";
        for (int blk = 0; blk < 15; blk++) begin
            dens = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 399) == 0) async_reset($urandom_range(0, 2));
                else step($urandom_range(0, 99) < dens);
            end
        end

        #20;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
